// File: rtl/byte_data_memory_pkg.sv
// rtl/byte_data_memory_pkg.sv - shared encodings for the byte-addressable data memory
//
// Holds the load/store size encodings (funct3), the controller FSM state
// encoding and small sign-extension helpers used by the lane aligner.
package byte_data_memory_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    localparam int unsigned WORD_W = 32;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/byte_data_memory_lane_align.sv
// rtl/byte_data_memory_lane_align.sv - combinational lane select, extension and access-error decode
//
// Module mem_lane_align.
// Ports:
//   funct3     in   access size/sign
//   offset     in   byte offset within the word (address[1:0])
//   mem_read   in   load strobe
//   mem_write  in   store strobe
//   word       in   current contents of the addressed word
//   write_data in   right-aligned store data
//   read_data  out  aligned/extended load result, 0 when no legal load
//   access_err out  strobe active with illegal funct3 or misaligned address
//   byte_en    out  byte lanes to write, 0 when no legal store
//   lane_data  out  store data replicated into every candidate lane
module mem_lane_align
    import byte_data_memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] word,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        access_err,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data
);

    logic        illegal;
    logic        illegal_store;
    logic        misaligned;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [3:0]  store_be;

    always_comb begin
        illegal       = 1'b0;
        illegal_store = 1'b0;
        misaligned    = 1'b0;
        load_val      = '0;
        store_be      = '0;
        lane_data     = '0;
        lane_byte     = word[{offset, 3'b000} +: 8];
        lane_half     = offset[1] ? word[31:16] : word[15:0];

        case (funct3_e'(funct3))
            F3_B: begin
                load_val  = sext8(lane_byte);
                store_be  = 4'b0001 << offset;
                lane_data = {4{write_data[7:0]}};
            end
            F3_H: begin
                misaligned = offset[0];
                load_val   = sext16(lane_half);
                store_be   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{write_data[15:0]}};
            end
            F3_W: begin
                misaligned = (offset != 2'b00);
                load_val   = word;
                store_be   = 4'b1111;
                lane_data  = write_data;
            end
            F3_BU: begin
                // Unsigned variants exist only for loads.
                illegal_store = 1'b1;
                load_val      = {24'b0, lane_byte};
            end
            F3_HU: begin
                illegal_store = 1'b1;
                misaligned    = offset[0];
                load_val      = {16'b0, lane_half};
            end
            default: illegal = 1'b1;
        endcase

        access_err = (mem_read | mem_write)
                   & (illegal | misaligned | (mem_write & illegal_store));
        read_data  = (mem_read && !access_err) ? load_val : '0;
        byte_en    = (mem_write && !access_err) ? store_be : 4'b0000;
    end

endmodule

// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - byte-addressable data memory with clear sweep and debug port
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   address, write_data      CPU byte address and right-aligned store data
//   mem_write, mem_read      CPU store/load strobes
//   funct3                   access size/sign
//   read_data, access_err    combinational load result and error flag
//   busy                     high while the post-reset clear sweep runs
//   cpu_halt                 CPU frozen, debug access permitted
//   dbg_req/rw/addr/wdata    level debug request, held until dbg_ack
//   dbg_ack, dbg_rdata       one-cycle completion pulse and registered read word
//   mem0                     live contents of word 0
module byte_data_memory
    import byte_data_memory_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DBG_ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [2:0]            funct3,
    output logic [31:0]           read_data,
    output logic                  access_err,
    output logic                  busy,
    input  logic                  cpu_halt,
    input  logic                  dbg_req,
    input  logic                  dbg_rw,
    input  logic [DBG_ADDR_W-1:0] dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_ack,
    output logic [31:0]           dbg_rdata,
    output logic [31:0]           mem0
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    state_e        state;
    state_e        state_next;
    logic [AW-1:0] clear_ptr;

    logic [AW-1:0] word_idx;
    logic [AW-1:0] dbg_idx;
    logic [31:0]   align_rdata;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data;
    logic          cpu_store;
    logic          dbg_accept;
    logic          unused_addr;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign word_idx    = address[AW+1:2];
    assign unused_addr = ^address[31:AW+2];
    assign dbg_idx     = AW'(dbg_addr);

    mem_lane_align u_align (
        .funct3     (funct3),
        .offset     (address[1:0]),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .word       (mem[word_idx]),
        .write_data (write_data),
        .read_data  (align_rdata),
        .access_err (access_err),
        .byte_en    (byte_en),
        .lane_data  (lane_data)
    );

    assign busy      = (state == ST_CLEAR);
    assign read_data = busy ? 32'h0 : align_rdata;
    assign cpu_store = !busy && (byte_en != 4'b0000);
    assign dbg_ack   = (state == ST_ACK);
    assign mem0      = mem[0];

    // A pending CPU store wins; the debug request simply waits for a free cycle.
    assign dbg_accept = (state == ST_IDLE) && dbg_req && cpu_halt && !mem_write;

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clear_ptr == AW'(DEPTH - 1)) state_next = ST_IDLE;
            ST_IDLE:  if (dbg_accept) state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
            dbg_rdata <= '0;
        end else begin
            state <= state_next;
            if (busy) clear_ptr <= clear_ptr + 1'b1;
            if (dbg_accept && !dbg_rw) dbg_rdata <= mem[dbg_idx];
        end
    end

    // Storage has no reset; contents are only defined once the sweep has run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[clear_ptr] <= '0;
            end else if (cpu_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end else if (dbg_accept && dbg_rw) begin
                mem[dbg_idx] <= dbg_wdata;
            end
        end
    end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words; SHALL be a power of two and at least 2.
REQ-002 Parameter DBG_ADDR_W, default 9, debug word-address width; SHALL be at most log2(DEPTH).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  32  CPU byte address; word index = address[log2(DEPTH)+1:2]; upper bits ignored (wrap).
REQ-006 write_data  in  32  CPU store data, right-aligned.
REQ-007 mem_write  in  1  CPU store strobe.
REQ-008 mem_read  in  1  CPU load strobe.
REQ-009 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 read_data  out  32  combinational load result, aligned and extended.
REQ-011 access_err  out  1  combinational: strobe active with illegal funct3 or misaligned address.
REQ-012 busy  out  1  high while the clear sweep runs.
REQ-013 cpu_halt  in  1  CPU frozen; debug port permitted.
REQ-014 dbg_req  in  1  debug request, level, held until dbg_ack.
REQ-015 dbg_rw  in  1  1 = debug write, 0 = debug read.
REQ-016 dbg_addr  in  DBG_ADDR_W  debug word address.
REQ-017 dbg_wdata  in  32  debug write word.
REQ-018 dbg_ack  out  1  one-cycle completion pulse.
REQ-019 dbg_rdata  out  32  registered debug read word, valid with dbg_ack and held after it.
REQ-020 mem0  out  32  live contents of word 0.

Function
REQ-021 FSM states CLEAR, IDLE, ACK; CLEAR writes zero to word clear_ptr each cycle, clear_ptr increments, and the FSM moves to IDLE after writing word DEPTH-1 (DEPTH cycles total).
REQ-022 In CLEAR, CPU stores and debug requests SHALL be ignored and read_data SHALL be 0.
REQ-023 Stores: SB writes write_data[7:0] to byte lane address[1:0]; SH writes write_data[15:0] to half lane address[1]; SW writes the whole word; other lanes unchanged.
REQ-024 Loads: B/H sign-extend, BU/HU zero-extend the selected lane; W returns the word; read_data = 0 when mem_read=0.
REQ-025 Misaligned = H/HU with address[0]=1, or W with address[1:0]!=0; illegal = funct3 011/110/111, or 100/101 on a store.
REQ-026 When misaligned or illegal, access_err=1, the store SHALL be suppressed, and read_data SHALL be 0.
REQ-027 mem_read and mem_write in the same cycle to the same word: read_data SHALL return the pre-write contents.
REQ-028 A debug request is accepted in IDLE when dbg_req=1, cpu_halt=1 and mem_write=0; a CPU store takes priority and the request waits.
REQ-029 On accept, a write updates the word at dbg_addr, or a read captures it into dbg_rdata; the FSM enters ACK, driving dbg_ack=1 for exactly the next cycle, then returns to IDLE.
REQ-030 No request is accepted in ACK, so a held dbg_req SHALL NOT double-issue; latency is one cycle from accept to dbg_ack.
REQ-031 CPU stores remain legal during ACK.

Reset
REQ-032 Reset SHALL force state=CLEAR, clear_ptr=0, dbg_ack=0, dbg_rdata=0; busy=1 from the next cycle until the sweep completes.
REQ-033 Reset mid-sweep SHALL restart the sweep at word 0; reset during ACK SHALL cancel the pulse.
REQ-034 Memory contents SHALL be defined only after the sweep; no initial blocks SHALL be relied on.

Structure
REQ-035 A shared package SHALL hold the funct3 encodings and FSM state encodings.
REQ-036 Lane select, extension and error decode SHALL sit in one combinational sub-module, mem_lane_align; the array, FSM and debug port stay in byte_data_memory.

Verification
REQ-037 Reset, then wait: busy=1 for exactly 1024 cycles; afterwards mem0=0 and a LW at 0x3FC returns 0.
REQ-038 SW 0x80FF7F01 at 0x10; then LB 0x10 -> 0x00000001, LB 0x11 -> 0x0000007F, LB 0x12 -> 0xFFFFFFFF, LBU 0x12 -> 0x000000FF, LH 0x12 -> 0xFFFF80FF.
REQ-039 SB 0xAA at 0x21 over word 0 -> LW 0x20 = 0x0000AA00; SH 0x1234 at 0x22 -> LW 0x20 = 0x1234AA00.
REQ-040 SW at 0x06 -> access_err=1, word unchanged; LH at 0x05 -> read_data 0, access_err=1; funct3 011 -> access_err=1.
REQ-041 cpu_halt=1, debug write 0xDEADBEEF at dbg_addr 3, then debug read 3 -> dbg_ack single pulse each, dbg_rdata 0xDEADBEEF, LW 0x0C agrees; dbg_req held two extra cycles -> no second ack.
REQ-042 Assert reset at sweep cycle 500 after SW 0x55 to word 0 -> sweep restarts, busy 1024 further cycles, mem0=0.
